// File: rtl/div_arb_pkg.sv
// Shared types for the divider arbiter: FSM states, response record, data width.
package div_arb_pkg;

   localparam int DIV_W = 32;
   localparam logic [DIV_W-1:0] DZ_QUT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [DIV_W-1:0] qut;
      logic [DIV_W-1:0] rmd;
      logic             dz;
      logic             err;
   } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Zero latency; no flow control of its own, the caller gates the grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int  c;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         c = int'(ptr_i) + k;
         if (c >= N) c = c - N;
         if (!found && req_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = c[IW-1:0];
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/div32_arbiter.sv
// Shares one iterative div32 among NREQ requesters; accept->start 1 cycle, done->rsp 1 cycle.
// One operation in flight; req_ready only in IDLE, response held until the owner's rsp_ready.
module div32_arbiter
   import div_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*DIV_W-1:0] req_src1,
   input  logic [NREQ*DIV_W-1:0] req_src2,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [DIV_W-1:0]      rsp_qut,
   output logic [DIV_W-1:0]      rsp_rmd,
   output logic                  rsp_dz,
   output logic                  rsp_err,
   output logic                  div_start,
   output logic [DIV_W-1:0]      div_src1,
   output logic [DIV_W-1:0]      div_src2,
   input  logic [DIV_W-1:0]      div_qut,
   input  logic [DIV_W-1:0]      div_rmd,
   input  logic                  div_done
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gidx_q, gidx_d;
   logic [DIV_W-1:0] src1_q, src1_d;
   logic [DIV_W-1:0] src2_q, src2_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   rsp_t             rsp_q, rsp_d;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic [DIV_W-1:0] sel_src1, sel_src2;
   logic             accept, rsp_done;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign req_ready = (n_rst && state_q == ST_IDLE) ? gnt : '0;
   assign accept    = gnt_any && n_rst && (state_q == ST_IDLE);
   assign sel_src1  = req_src1[gnt_idx*DIV_W +: DIV_W];
   assign sel_src2  = req_src2[gnt_idx*DIV_W +: DIV_W];
   assign rsp_done  = (state_q == ST_RESP) && rsp_ready[gidx_q];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      cnt_d   = cnt_q;
      rsp_d   = rsp_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               gidx_d = gnt_idx;
               src1_d = sel_src1;
               src2_d = sel_src2;
               ptr_d  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               // Zero divisor never reaches the divider; answer is formed here.
               if (sel_src2 == '0) begin
                  rsp_d   = '{qut: DZ_QUT, rmd: sel_src1, dz: 1'b1, err: 1'b0};
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (div_done) begin
               rsp_d   = '{qut: div_qut, rmd: div_rmd, dz: 1'b0, err: 1'b0};
               state_d = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_d   = '{qut: '0, rmd: '0, dz: 1'b0, err: 1'b1};
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         cnt_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
      end
   end

   assign div_start = (state_q == ST_ISSUE);
   assign div_src1  = src1_q;
   assign div_src2  = src2_q;
   assign rsp_valid = (state_q == ST_RESP) ? (NREQ'(1) << gidx_q) : '0;
   assign rsp_qut   = rsp_q.qut;
   assign rsp_rmd   = rsp_q.rmd;
   assign rsp_dz    = rsp_q.dz;
   assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_div32_arbiter.sv
// Bench: requesters and a div32 stub driven per cycle, checked against a
// transaction-level model (round-robin order, arithmetic results, spec latencies).
module tb_div32_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int NEVER   = 32'h7fff_ffff;

   logic                 clk, n_rst;
   logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*32-1:0]   req_src1, req_src2;
   logic [31:0]          rsp_qut, rsp_rmd, div_src1, div_src2, div_qut, div_rmd;
   logic                 rsp_dz, rsp_err, div_start, div_done;

   div32_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_qut(rsp_qut), .rsp_rmd(rsp_rmd), .rsp_dz(rsp_dz), .rsp_err(rsp_err),
      .div_start(div_start), .div_src1(div_src1), .div_src2(div_src2),
      .div_qut(div_qut), .div_rmd(div_rmd), .div_done(div_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // requester side and model state
   bit   [NREQ-1:0] vld;
   logic [31:0]     s1 [NREQ];
   logic [31:0]     s2 [NREQ];
   bit              rst_drv, busy, e_dz, e_hang, e_err, stub_pend;
   bit              rnd_rdy, spur, hang, hang_rnd;
   int              gen_mode, m_ptr, eg, acc_cyc, acc_win, exp_from, stub_at;
   int              bp, low_left, force_lat, n_starts, first_rsp_cyc, start_cyc, hs_cyc, last_owner;
   logic [31:0]     e_a, e_b, e_q, e_r, st_a, st_b, last_q, last_r;
   bit              last_dz, last_err;
   int              order [$];

   function automatic int rr_pick(input bit [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic window();
      int              win;
      bit              in_rsp, exp_st;
      logic [NREQ-1:0] exp_rdy, exp_rv, rr;
      @(negedge clk);
      n_rst = rst_drv;
      for (int i = 0; i < NREQ; i++) begin
         if (gen_mode != 0 && !vld[i] && (gen_mode == 2 || $urandom_range(0, 2) == 0)) begin
            vld[i] = 1'b1;
            s1[i]  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1000));
            case ($urandom_range(0, 7))
               0:       s2[i] = 32'd0;
               1, 2:    s2[i] = 32'($urandom_range(1, 15));
               default: s2[i] = $urandom;
            endcase
         end
      end
      req_valid = vld;
      for (int i = 0; i < NREQ; i++) begin
         req_src1[i*32 +: 32] = s1[i];
         req_src2[i*32 +: 32] = s2[i];
      end
      div_done = 1'b0;
      div_qut  = $urandom;
      div_rmd  = $urandom;
      if (stub_pend && cyc == stub_at) begin
         div_done  = 1'b1;
         div_qut   = st_a / st_b;
         div_rmd   = st_a % st_b;
         stub_pend = 1'b0;
         exp_from  = cyc + 1;
      end else if (spur && (!busy || cyc >= exp_from) && $urandom_range(0, 7) == 0) begin
         div_done = 1'b1;
      end
      rr = NREQ'($urandom);
      if (busy && cyc >= exp_from) begin
         if (cyc == exp_from) low_left = bp;
         if (low_left > 0) begin
            rr[eg] = 1'b0;
            low_left--;
         end else begin
            rr[eg] = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
      rsp_ready = rr;
      #1;
      n_starts += int'(div_start);
      win     = rr_pick(vld, m_ptr);
      exp_rdy = '0;
      if (n_rst && !busy && win >= 0) exp_rdy[win] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("ready_onehot0", $onehot0(req_ready), 1'b1);
      in_rsp = 1'b0;
      if (n_rst) begin
         in_rsp = busy && cyc >= exp_from;
         exp_rv = '0;
         if (in_rsp) exp_rv[eg] = 1'b1;
         check_eq("rsp_valid", rsp_valid, exp_rv);
         if (in_rsp) begin
            check_eq("rsp_qut", rsp_qut, e_q);
            check_eq("rsp_rmd", rsp_rmd, e_r);
            check_eq("rsp_dz", rsp_dz, e_dz);
            check_eq("rsp_err", rsp_err, e_err);
            if (cyc == exp_from) first_rsp_cyc = cyc;
         end
         exp_st = busy && !e_dz && cyc == acc_cyc;
         check_eq("div_start", div_start, exp_st);
         if (exp_st) begin
            check_eq("div_src1", div_src1, e_a);
            check_eq("div_src2", div_src2, e_b);
            start_cyc = cyc;
         end
         if (div_start) begin
            st_a      = div_src1;
            st_b      = div_src2;
            stub_pend = !e_hang;
            stub_at   = cyc + ((force_lat > 0) ? force_lat : $urandom_range(1, 10));
         end
      end
      if (!n_rst) begin
         busy      = 1'b0;
         m_ptr     = 0;
         stub_pend = 1'b0;
      end else if (!busy) begin
         if (win >= 0) begin
            busy    = 1'b1;
            eg      = win;
            acc_win = cyc;
            acc_cyc = cyc + 1;
            e_a     = s1[win];
            e_b     = s2[win];
            e_dz    = (e_b == 32'd0);
            e_hang  = !e_dz && (hang || (hang_rnd && $urandom_range(0, 15) == 0));
            e_err   = e_hang;
            e_q     = e_dz ? 32'hFFFF_FFFF : (e_hang ? 32'd0 : e_a / e_b);
            e_r     = e_dz ? e_a : (e_hang ? 32'd0 : e_a % e_b);
            exp_from = e_dz ? acc_cyc : (e_hang ? acc_cyc + TIMEOUT + 1 : NEVER);
            m_ptr   = (win + 1) % NREQ;
            vld[win] = 1'b0;
            order.push_back(win);
         end
      end else if (in_rsp && rsp_ready[eg]) begin
         busy       = 1'b0;
         hs_cyc     = cyc;
         last_owner = eg;
         last_q     = rsp_qut;
         last_r     = rsp_rmd;
         last_dz    = rsp_dz;
         last_err   = rsp_err;
      end
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int k;
      k = 0;
      while ((busy || vld != '0) && k < budget) begin
         window();
         k++;
      end
      check_eq({tag, "_drained"}, (busy || vld != '0), 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rsp_valid"}, rsp_valid, '0);
      check_eq({tag, "_rsp_qut"}, rsp_qut, 32'd0);
      check_eq({tag, "_rsp_rmd"}, rsp_rmd, 32'd0);
      check_eq({tag, "_rsp_dz"}, rsp_dz, 1'b0);
      check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
      check_eq({tag, "_div_start"}, div_start, 1'b0);
      check_eq({tag, "_div_src1"}, div_src1, 32'd0);
      check_eq({tag, "_div_src2"}, div_src2, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int k, n0, h0;
      int exp_ord [5];
      exp_ord = '{0, 1, 2, 3, 0};
      n_rst = 1'b0; req_valid = '0; req_src1 = '0; req_src2 = '0; rsp_ready = '0;
      div_qut = '0; div_rmd = '0; div_done = 1'b0;
      for (int i = 0; i < NREQ; i++) begin s1[i] = '0; s2[i] = '0; end
      vld = '0; rst_drv = 1'b0; busy = 1'b0; stub_pend = 1'b0; gen_mode = 0;
      rnd_rdy = 1'b0; spur = 1'b0; hang = 1'b0; hang_rnd = 1'b0; bp = 0; low_left = 0;
      force_lat = 0; n_starts = 0; m_ptr = 0; exp_from = NEVER; acc_cyc = -1;

      // reset: requester 0 already valid, must not see req_ready
      vld[0] = 1'b1; s1[0] = 32'd5; s2[0] = 32'd1;
      window();
      window();
      check_reset_outputs("reset");
      vld[0] = 1'b0;
      rst_drv = 1'b1;

      // single request 100/7
      vld[0] = 1'b1; s1[0] = 32'd100; s2[0] = 32'd7;
      n0 = n_starts;
      run_until_idle("single", 100);
      check_eq("single_qut", last_q, 32'd14);
      check_eq("single_rmd", last_r, 32'd2);
      check_eq("single_dz", last_dz, 1'b0);
      check_eq("single_err", last_err, 1'b0);
      check_eq("single_owner", last_owner, 0);
      check_eq("single_starts", n_starts - n0, 1);

      // zero divisor on requester 2
      vld[2] = 1'b1; s1[2] = 32'h1234; s2[2] = 32'd0;
      n0 = n_starts;
      run_until_idle("dz", 100);
      check_eq("dz_qut", last_q, 32'hFFFF_FFFF);
      check_eq("dz_rmd", last_r, 32'h1234);
      check_eq("dz_flag", last_dz, 1'b1);
      check_eq("dz_owner", last_owner, 2);
      check_eq("dz_latency", first_rsp_cyc - acc_win, 1);
      check_eq("dz_no_start", n_starts - n0, 0);

      // backpressure: 5 cycles of rsp_ready low, a second requester waiting
      bp = 5;
      vld[1] = 1'b1; s1[1] = 32'd60; s2[1] = 32'd7;
      window();
      vld[3] = 1'b1; s1[3] = 32'd9; s2[3] = 32'd4;
      k = 0;
      while (busy && k < 200) begin window(); k++; end
      check_eq("bp_gap", hs_cyc - first_rsp_cyc, 5);
      check_eq("bp_owner", last_owner, 1);
      check_eq("bp_qut", last_q, 32'd8);
      bp = 0;
      h0 = hs_cyc;
      run_until_idle("bp", 200);
      check_eq("bp_next_grant", acc_win - h0, 1);
      check_eq("bp_next_owner", last_owner, 3);

      // timeout: divider never completes
      hang = 1'b1;
      vld[1] = 1'b1; s1[1] = 32'd77; s2[1] = 32'd5;
      run_until_idle("tmo", 300);
      check_eq("tmo_err", last_err, 1'b1);
      check_eq("tmo_qut", last_q, 32'd0);
      check_eq("tmo_rmd", last_r, 32'd0);
      check_eq("tmo_latency", first_rsp_cyc - start_cyc, TIMEOUT + 1);
      hang = 1'b0;

      // reset while in WAIT
      force_lat = 20;
      vld[2] = 1'b1; s1[2] = 32'd50; s2[2] = 32'd3;
      k = 0;
      do begin window(); k++; end while (!(busy && cyc == acc_cyc + 2) && k < 50);
      check_eq("midrst_in_wait", busy && cyc == acc_cyc + 2, 1'b1);
      rst_drv = 1'b0;
      window();
      rst_drv = 1'b1;
      window();
      check_reset_outputs("midrst");
      force_lat = 0;

      // fairness: all requesters continuously valid, order restarts at 0
      order.delete();
      gen_mode = 2;
      k = 0;
      while (order.size() < 5 && k < 1000) begin window(); k++; end
      for (int j = 0; j < 5; j++)
         check_eq("fair_order", (j < order.size()) ? order[j] : -1, exp_ord[j]);
      gen_mode = 0;
      run_until_idle("fair", 800);

      // randomized traffic
      order.delete();
      gen_mode = 1; rnd_rdy = 1'b1; spur = 1'b1; hang_rnd = 1'b1;
      repeat (4000) window();
      gen_mode = 0;
      run_until_idle("rand", 1500);
      check_eq("rand_activity", order.size() > 50, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div32_arbiter.md
# div32_arbiter

Round-robin arbiter and sequencer that shares one `div32` iterative divider between `NREQ` independent requesters. Each requester presents a valid/ready operand pair. The block grants one requester, pulses the divider `start`, waits for `done`, and returns quotient and remainder to the granted requester over a valid/ready response channel. Divide-by-zero is resolved locally without using the divider. A watchdog flags a divider that never completes.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum cycles to wait for `div_done` after `div_start`.
- `clk` in 1: single clock, all logic on rising edge.
- `n_rst` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept, at most one bit high.
- `req_src1` in NREQ*32: dividends, requester i at bits [32i+31:32i].
- `req_src2` in NREQ*32: divisors, same packing.
- `rsp_valid` out NREQ: one-hot response valid to the owning requester.
- `rsp_ready` in NREQ: per-requester response accept.
- `rsp_qut` out 32: quotient.
- `rsp_rmd` out 32: remainder.
- `rsp_dz` out 1: divisor was zero.
- `rsp_err` out 1: divider timed out; `rsp_qut`/`rsp_rmd` are 0.
- `div_start` out 1: one-cycle start pulse to `div32`.
- `div_src1` out 32: dividend to `div32`.
- `div_src2` out 32: divisor to `div32`.
- `div_qut` in 32: quotient from `div32`.
- `div_rmd` in 32: remainder from `div32`.
- `div_done` in 1: completion from `div32`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Round-robin select among asserted `req_valid`, starting at `ptr`.
  - Drive `req_ready[g]=1` combinationally for the winner g only.
  - On the accept edge:
    - latch `src1`, `src2` and `g`;
    - set `ptr = (g+1) mod NREQ`.
  - If latched `src2 == 0`: go to RESP with `qut=32'hFFFF_FFFF`, `rmd=src1`, `dz=1`. The divider is not started.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `div_start=1` for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - Increment the counter each cycle.
  - On `div_done=1`: capture `div_qut`/`div_rmd`, go to RESP.
  - If the counter reaches `TIMEOUT` with no done: set `err=1`, results 0, go to RESP.
- **RESP**
  - Hold `rsp_valid[g]=1` and hold all `rsp_*` fields stable.
  - On `rsp_ready[g]=1`: go to IDLE.
- `req_ready` is 0 in every state except IDLE, so there is at most one outstanding operation.
- Requesters must hold `req_valid`/operands until accepted. The arbiter may regrant the same requester only after cycling through all others that are requesting.
- `div_src1`/`div_src2` are driven from the latched operands in all states; they are 0 after reset.
- All division is unsigned, 32-bit; no sign handling.

## Timing
- Reset (`n_rst=0` at a rising edge), all clearing on that edge:
  - state=IDLE, `ptr=0`;
  - `rsp_valid=0`, `rsp_qut=0`, `rsp_rmd=0`, `rsp_dz=0`, `rsp_err=0`;
  - `div_start=0`, `div_src1=0`, `div_src2=0`.
  - `req_ready` is 0 while `n_rst=0`.
- Reset mid-operation:
  - the in-flight result is discarded and no response is issued;
  - `div32` shares `n_rst`.
- Latency:
  - accept edge to `div_start` high: 1 cycle;
  - `div_done` sampled to `rsp_valid` high: 1 cycle.
  - The zero-divisor path is accept edge to `rsp_valid` in 1 cycle.
- `div_done` is ignored in the ISSUE cycle and in all states other than WAIT.
- Simultaneous requests: only the winner sees `req_ready`; the others wait.
- `rsp_ready` asserted with `rsp_valid` in the same cycle completes the transfer. The next grant can occur the cycle after.
- Back-to-back throughput: one operation per divider latency + 3 cycles.

## Structure
- Package `div_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - `DIV_W=32`;
  - `DZ_QUT=32'hFFFF_FFFF`.
- Sub-module `rr_arbiter`: combinational round-robin grant.
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant, encoded index.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- **Single request:** requester 0 sends 100/7 → `div_start` pulses once; then `rsp_valid[0]` with `qut=14`, `rmd=2`, `dz=0`, `err=0`.
- **Fairness:** all four requesters assert simultaneously and continuously → service order 0,1,2,3,0; `req_ready` is never multi-hot.
- **Zero divisor:** requester 2 sends `0x1234`/0 → `rsp_valid[2]` one cycle after accept with `qut=0xFFFFFFFF`, `rmd=0x1234`, `dz=1`; `div_start` never asserts.
- **Backpressure:** `rsp_ready` held low 5 cycles → `rsp_valid`/data stable for all 5, no new `req_ready`; grant follows the cycle after the handshake.
- **Reset mid-WAIT:** `n_rst` low one edge during WAIT → all outputs 0 and `ptr=0` after that edge; no stale response appears afterwards.
- **Timeout:** stub divider never asserts done → `rsp_err=1`, `qut=rmd=0`, exactly `TIMEOUT` cycles after the ISSUE cycle plus 1.
